s2_window_sequencer: RTL and testbench

// Drives the stage-2 tensor-processing datapath. After a start pulse it issues the
// (row, col, channel-base) coordinates of every 3x3 window of one 8x8 input plane,
// in raster order, using a valid/ready handshake. Issue is credit-limited.
// It collects the in-order per-window results and writes them to the output

---
 rtl/s2_pkg.sv | 30 +++
 rtl/s2_raster_counter.sv | 50 +++++
 rtl/s2_window_sequencer.sv | 168 ++++++++++++++++
 tb/tb_s2_window_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2_pkg.sv
// Shared constants, types and helpers for the stage-2 window sequencer.
// Plane geometry is fixed here; the credit limit stays a parameter of the top.
package s2_pkg;

  localparam int DATA_W  = 17;
  localparam int IN_DIM  = 8;
  localparam int K       = 3;
  localparam int OUT_DIM = IN_DIM - K + 1;
  localparam int N_WIN   = OUT_DIM * OUT_DIM;
  localparam int COORD_W = $clog2(OUT_DIM);
  localparam int ADDR_W  = $clog2(N_WIN);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [1:0]         ch_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Linear output-map address of a window's top-left corner.
  function automatic addr_t raster_addr(coord_t row, coord_t col);
    return addr_t'(row) * addr_t'(OUT_DIM) + addr_t'(col);
  endfunction

endpackage

// File: rtl/s2_raster_counter.sv
// Row/column raster counter over the OUT_DIM x OUT_DIM window grid.
// last_o flags the bottom-right position so the owner can detect the final step.
module s2_raster_counter
  import s2_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] LAST_C = COORD_W'(OUT_DIM - 1);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == LAST_C) begin
        col_d = '0;
        row_d = (row_q == LAST_C) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == LAST_C) && (col_q == LAST_C);

endmodule

// File: rtl/s2_window_sequencer.sv
// Issues every 3x3 window of one input plane under a credit limit and writes the
// in-order results to the output feature map.
//   state    | meaning
//   ST_IDLE  | waiting for start; outputs quiet
//   ST_ISSUE | issuing windows (credit-limited) and collecting results
//   ST_DRAIN | all windows issued; collecting remaining results
//   ST_DONE  | final write cycle; done pulses, back to idle next cycle
module s2_window_sequencer
  import s2_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         ch_sel,
  output logic               busy,
  output logic               done,
  output logic               err_unexp,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic [1:0]         win_ch,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [DATA_W-1:0]  res_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  state_t             state_q;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic               busy_q, done_q, err_q;
  logic               win_valid_q, res_ready_q;
  logic               wr_en_q;
  logic [1:0]         ch_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic               start_go, issue, accept, drop;
  logic               iss_last, res_last;
  logic [COORD_W-1:0] iss_row, iss_col;
  logic [COORD_W-1:0] res_row, res_col;

  assign start_go = (state_q == ST_IDLE) && start;
  assign issue    = win_valid_q && win_ready;
  assign accept   = res_valid && res_ready_q && (outst_q != '0);
  assign drop     = res_valid && !(res_ready_q && (outst_q != '0));

  s2_raster_counter u_iss_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_go),
    .inc_i  (issue),
    .row_o  (iss_row),
    .col_o  (iss_col),
    .last_o (iss_last)
  );

  s2_raster_counter u_res_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_go),
    .inc_i  (accept),
    .row_o  (res_row),
    .col_o  (res_col),
    .last_o (res_last)
  );

  // Credits: one per window in flight; simultaneous issue and accept cancel out.
  always_comb begin
    outst_d = outst_q;
    if (start_go) begin
      outst_d = '0;
    end else if (issue && !accept) begin
      outst_d = outst_q + 1'b1;
    end else if (accept && !issue) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      outst_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      ch_q        <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      outst_q <= outst_d;
      wr_en_q <= accept;
      done_q  <= 1'b0;
      if (accept) begin
        wr_addr_q <= raster_addr(res_row, res_col);
        wr_data_q <= res_data;
      end
      if (drop) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_ISSUE;
            ch_q        <= ch_sel;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            res_ready_q <= 1'b1;
            win_valid_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (accept && res_last) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            res_ready_q <= 1'b0;
            win_valid_q <= 1'b0;
          end else if (issue && iss_last) begin
            state_q     <= ST_DRAIN;
            win_valid_q <= 1'b0;
          end else begin
            win_valid_q <= (outst_d < MAX_OUT_C);
          end
        end
        ST_DRAIN: begin
          if (accept && res_last) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            res_ready_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          win_valid_q <= 1'b0;
          res_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_unexp = err_q;
  assign win_valid = win_valid_q;
  assign win_row   = iss_row;
  assign win_col   = iss_col;
  assign win_ch    = ch_q;
  assign res_ready = res_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_s2_window_sequencer.sv
// Scoreboard bench for s2_window_sequencer: directed runs push expected windows
// and writes; a negedge monitor pops and compares whatever the DUT presents.
module tb_s2_window_sequencer;
  import s2_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         ch_sel = 2'd0;
  logic               busy, done, err_unexp, win_valid;
  logic               win_ready = 1'b0;
  logic [COORD_W-1:0] win_row, win_col;
  logic [1:0]         win_ch;
  logic               res_valid = 1'b0;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data = '0;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  always #5 clk = ~clk;

  s2_window_sequencer #(.MAX_OUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ch_sel    (ch_sel),
    .busy      (busy),
    .done      (done),
    .err_unexp (err_unexp),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_ch    (win_ch),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct { int row; int col; int ch; } win_t;
  typedef struct { int addr; int data; } wr_t;

  win_t exp_win[$];
  wr_t  exp_wr[$];
  int   pend[$];

  int checks = 0;
  int errors = 0;
  int iss_cnt = 0, acc_cnt = 0, done_cnt = 0, wr_cnt = 0, outst_m = 0;
  bit iss_seen = 0, acc_seen = 0;
  int iss_addr = 0;
  int rdy_mode = 0;
  int res_limit = 1000000;
  bit force_res = 0;
  bit stall_prev = 0;
  int st_row = 0, st_col = 0, st_ch = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: everything seen here transfers at the following rising edge.
  always @(negedge clk) begin
    iss_seen = 1'b0;
    acc_seen = 1'b0;
    if (!rst_n) begin
      stall_prev = 1'b0;
      outst_m = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_row", win_row, st_row);
        chk("stall_col", win_col, st_col);
        chk("stall_ch", win_ch, st_ch);
      end
      stall_prev = win_valid && !win_ready;
      st_row = int'(win_row);
      st_col = int'(win_col);
      st_ch  = int'(win_ch);
      if (win_valid && win_ready) begin
        win_t e;
        iss_seen = 1'b1;
        iss_addr = int'(win_row) * OUT_DIM + int'(win_col);
        chk("credit_below_max", outst_m < 4, 1);
        chk("win_expected", exp_win.size() != 0, 1);
        if (exp_win.size() != 0) begin
          e = exp_win.pop_front();
          chk("win_row", win_row, e.row);
          chk("win_col", win_col, e.col);
          chk("win_ch", win_ch, e.ch);
        end
        iss_cnt++;
        outst_m++;
      end
      if (res_valid && res_ready) begin
        acc_seen = 1'b1;
        acc_cnt++;
        outst_m--;
      end
      if (wr_en) begin
        wr_t w;
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr", wr_addr, w.addr);
          chk("wr_data", wr_data, w.data);
          chk("done_on_last_wr", done, (w.addr == N_WIN - 1) ? 1 : 0);
        end
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("done_with_wr_en", wr_en, 1);
      end
    end
  end

  // Datapath model: answers each window with addr+100 one cycle after issue.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend.delete();
      res_valid = 1'b0;
      res_data  = '0;
      win_ready = 1'b0;
    end else begin
      if (acc_seen && pend.size() != 0) void'(pend.pop_front());
      if (iss_seen) pend.push_back(iss_addr);
      if (force_res) begin
        res_valid = 1'b1;
        res_data  = DATA_W'(17'h1ABCD);
      end else if (pend.size() != 0 && acc_cnt < res_limit) begin
        res_valid = 1'b1;
        res_data  = DATA_W'(pend[0] + 100);
      end else begin
        res_valid = 1'b0;
        res_data  = '0;
      end
      case (rdy_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = 1'($urandom_range(0, 1));
        default: win_ready = 1'b0;
      endcase
    end
  end

  task automatic push_run(input int ch);
    for (int r = 0; r < OUT_DIM; r++) begin
      for (int c = 0; c < OUT_DIM; c++) begin
        exp_win.push_back('{r, c, ch});
        exp_wr.push_back('{r * OUT_DIM + c, r * OUT_DIM + c + 100});
      end
    end
  endtask

  task automatic do_start(input int ch);
    @(posedge clk);
    #2;
    ch_sel = 2'(ch);
    start  = 1'b1;
    @(posedge clk);
    #2;
    start  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_unexp, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_ch"}, win_ch, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt, d0 + 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_win_left"}, exp_win.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    int wr0;
    int d0;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Idle after reset: nothing moves.
    repeat (5) begin
      @(negedge clk);
      check_zero("idle");
    end

    // Full run, always ready.
    rdy_mode = 0;
    push_run(2);
    do_start(2);
    @(negedge clk);
    chk("t2_busy", busy, 1);
    wait_done("t2", 400);

    // Full run, random ready.
    rdy_mode = 1;
    push_run(2);
    do_start(2);
    wait_done("t3", 1500);
    rdy_mode = 0;

    // Results withheld: credit limit caps issue at 4.
    res_limit = acc_cnt;
    base = iss_cnt;
    push_run(1);
    do_start(1);
    repeat (15) @(negedge clk);
    chk("t4_issues_held", iss_cnt - base, 4);
    chk("t4_win_valid_low", win_valid, 0);
    res_limit = acc_cnt + 1;
    repeat (10) @(negedge clk);
    chk("t4_issues_after_one", iss_cnt - base, 5);
    chk("t4_win_valid_low2", win_valid, 0);

    // Back-to-back results with issue in the same cycles.
    res_limit = acc_cnt + 3;
    repeat (12) @(negedge clk);
    chk("t5_issues", iss_cnt - base, 8);
    chk("t5_outstanding", outst_m, 4);
    res_limit = 1000000;
    wait_done("t45", 400);

    // Stray result in IDLE: no write, sticky error.
    wr0 = wr_cnt;
    @(posedge clk);
    force_res = 1'b1;
    @(posedge clk);
    force_res = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_err_set", err_unexp, 1);
    chk("t5_no_write", wr_cnt, wr0);
    repeat (4) @(negedge clk);
    chk("t5_err_held", err_unexp, 1);

    // Reset after the 20th issue aborts the run.
    push_run(3);
    base = iss_cnt;
    do_start(3);
    @(negedge clk);
    chk("t6_err_cleared", err_unexp, 0);
    n = 0;
    while (iss_cnt - base < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_20", iss_cnt - base, 20);
    d0 = done_cnt;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    exp_win.delete();
    exp_wr.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    check_zero("t6_after_rst");

    // Restart from (0,0); a start pulse mid-run must be ignored.
    push_run(0);
    do_start(0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    ch_sel = 2'd2;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start  = 1'b0;
    @(negedge clk);
    chk("t6_busy_kept", busy, 1);
    wait_done("t6b", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
